// File: rtl/toggle_event_tx.sv
// Toggle-handshake event transmitter.
// Each accepted evt_pulse is queued in a saturating counter and issued to the
// receiving domain as one transition of sig_tog. The next event is sent only
// after the receiver echoes the level back on ack_tog and a fixed idle gap
// has elapsed.
module toggle_event_tx #(
   parameter int CNT_W   = 4,
   parameter int GAP_CYC = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             evt_pulse,
   input  logic             ack_tog,
   input  logic             clr_ovf,
   output logic             sig_tog,
   output logic [CNT_W-1:0] pending,
   output logic             busy,
   output logic             overflow
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT_ACK = 2'd1,
      S_GAP      = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] PEND_MAX = '1;
   localparam logic [7:0]       GAP_LD   = 8'(GAP_CYC);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_ack_s0;
   logic             r_ack_s;
   logic             r_sig_tog;
   logic             r_overflow;
   logic [CNT_W-1:0] r_pending;
   logic [7:0]       r_gap_cnt;
   logic             w_issue;
   logic             w_ack_match;
   logic             w_ovf_set;

   // Two-flop synchronizer for the acknowledge toggle from the receiver domain.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ack_s0 <= 1'b0;
         r_ack_s  <= 1'b0;
      end else begin
         r_ack_s0 <= ack_tog;
         r_ack_s  <= r_ack_s0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // FSM next-state logic.
   // NOTE: the default assignment at the top keeps this block free of latches.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (r_pending != '0) w_state_nxt = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (w_ack_match) w_state_nxt = (GAP_CYC == 0) ? S_IDLE : S_GAP;
         end
         S_GAP: begin
            if (r_gap_cnt <= 8'd1) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs: issue strobe, acknowledge detect, and status derived from registered state only.
   always_comb begin
      w_issue     = (r_state == S_IDLE) && (r_pending != '0);
      w_ack_match = (r_state == S_WAIT_ACK) && (r_ack_s == r_sig_tog);
      w_ovf_set   = evt_pulse && !w_issue && (r_pending == PEND_MAX);
      busy        = (r_state != S_IDLE) || (r_pending != '0);
      sig_tog     = r_sig_tog;
      pending     = r_pending;
      overflow    = r_overflow;
   end

   // Gap counter: loaded on acknowledge, counts down while idling in GAP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gap_cnt <= 8'd0;
      end else if (w_ack_match && (GAP_CYC != 0)) begin
         r_gap_cnt <= GAP_LD;
      end else if ((r_state == S_GAP) && (r_gap_cnt != 8'd0)) begin
         r_gap_cnt <= r_gap_cnt - 8'd1;
      end
   end

   // Event toggle: one transition per issued event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_sig_tog <= 1'b0;
      else if (w_issue) r_sig_tog <= ~r_sig_tog;
   end

   // Pending counter: accept/issue on the same edge cancel; a full counter drops new events.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= '0;
      end else if (evt_pulse && !w_issue) begin
         if (r_pending != PEND_MAX) r_pending <= r_pending + 1'b1;
      end else if (w_issue && !evt_pulse) begin
         r_pending <= r_pending - 1'b1;
      end
   end

   // Sticky overflow flag; a new drop wins over a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         r_overflow <= 1'b0;
      else if (w_ovf_set) r_overflow <= 1'b1;
      else if (clr_ovf)   r_overflow <= 1'b0;
   end

endmodule

// File: tb/tb_toggle_event_tx.sv
// Bench for toggle_event_tx: two instances (CNT_W=2/GAP_CYC=2 and
// CNT_W=4/GAP_CYC=0) share the event/clear/reset inputs, each with its own
// receiver echoing sig_tog back on ack_tog after a programmable delay.
// A timestamp-based reference model predicts every output each cycle.
module tb_toggle_event_tx;

   localparam int MAXV[2] = '{3, 15};
   localparam int GAPV[2] = '{2, 0};

   logic       clk = 1'b0;
   logic       rst_n;
   logic       evt_pulse;
   logic       clr_ovf;
   logic [1:0] ack_tog;
   logic [1:0] sig_tog;
   logic [1:0] busy;
   logic [1:0] overflow;
   logic [1:0] pend_a;
   logic [3:0] pend_b;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: pending count, toggle level, waiting-for-ack flag,
   // earliest edge index at which the next issue may happen, ack pipeline.
   int   n_edge = 0;
   int   m_pend[2];
   logic m_tog[2];
   logic m_wait[2];
   int   m_ready[2];
   logic m_ovf[2];
   logic m_p0[2];
   logic m_p1[2];

   // Receiver behaviour.
   logic hold[2];
   int   dly[2];
   int   rc[2];
   logic rnd_dly = 1'b0;

   toggle_event_tx #(.CNT_W(2), .GAP_CYC(2)) u_dut_a (
      .clk      (clk),
      .rst_n    (rst_n),
      .evt_pulse(evt_pulse),
      .ack_tog  (ack_tog[0]),
      .clr_ovf  (clr_ovf),
      .sig_tog  (sig_tog[0]),
      .pending  (pend_a),
      .busy     (busy[0]),
      .overflow (overflow[0])
   );

   toggle_event_tx #(.CNT_W(4), .GAP_CYC(0)) u_dut_b (
      .clk      (clk),
      .rst_n    (rst_n),
      .evt_pulse(evt_pulse),
      .ack_tog  (ack_tog[1]),
      .clr_ovf  (clr_ovf),
      .sig_tog  (sig_tog[1]),
      .pending  (pend_b),
      .busy     (busy[1]),
      .overflow (overflow[1])
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pend_of(input int k);
      return (k == 0) ? {30'd0, pend_a} : {28'd0, pend_b};
   endfunction

   function automatic logic pred_issue(input int k);
      return !m_wait[k] && (n_edge >= m_ready[k]) && (m_pend[k] != 0);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_pend[k]  = 0;
         m_tog[k]   = 1'b0;
         m_wait[k]  = 1'b0;
         m_ready[k] = n_edge;
         m_ovf[k]   = 1'b0;
         m_p0[k]    = 1'b0;
         m_p1[k]    = 1'b0;
         rc[k]      = 0;
      end
   endtask

   task automatic check_reset_values(input string tag);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("%s_sig%0d", tag, k), {31'd0, sig_tog[k]}, 32'd0);
         check($sformatf("%s_pend%0d", tag, k), pend_of(k), 32'd0);
         check($sformatf("%s_busy%0d", tag, k), {31'd0, busy[k]}, 32'd0);
         check($sformatf("%s_ovf%0d", tag, k), {31'd0, overflow[k]}, 32'd0);
      end
   endtask

   // One clock cycle: drive inputs, let the receivers react, advance the
   // model across the edge, and compare all outputs shortly after the edge.
   task automatic step(input logic evt, input logic clr);
      logic ack_pre[2];
      logic issue;
      logic done;
      logic oset;
      evt_pulse = evt;
      clr_ovf   = clr;
      for (int k = 0; k < 2; k++) begin
         if (!hold[k] && (sig_tog[k] !== ack_tog[k])) begin
            rc[k]++;
            if (rc[k] >= dly[k]) begin
               ack_tog[k] = sig_tog[k];
               rc[k] = 0;
               if (rnd_dly) dly[k] = $urandom_range(1, 5);
            end
         end
         ack_pre[k] = ack_tog[k];
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         issue = pred_issue(k);
         done  = m_wait[k] && (m_p1[k] == m_tog[k]);
         oset  = 1'b0;
         if (issue) begin
            m_tog[k]  = ~m_tog[k];
            m_wait[k] = 1'b1;
         end
         if (done) begin
            m_wait[k]  = 1'b0;
            m_ready[k] = n_edge + GAPV[k] + 1;
         end
         if (evt && !issue) begin
            if (m_pend[k] == MAXV[k]) oset = 1'b1;
            else m_pend[k]++;
         end else if (issue && !evt) begin
            m_pend[k]--;
         end
         if (oset)     m_ovf[k] = 1'b1;
         else if (clr) m_ovf[k] = 1'b0;
         m_p1[k] = m_p0[k];
         m_p0[k] = ack_pre[k];
      end
      n_edge++;
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("sig%0d@%0d", k, n_edge), {31'd0, sig_tog[k]}, {31'd0, m_tog[k]});
         check($sformatf("pend%0d@%0d", k, n_edge), pend_of(k), 32'(m_pend[k]));
         check($sformatf("busy%0d@%0d", k, n_edge), {31'd0, busy[k]},
               {31'd0, m_wait[k] || (n_edge < m_ready[k]) || (m_pend[k] != 0)});
         check($sformatf("ovf%0d@%0d", k, n_edge), {31'd0, overflow[k]}, {31'd0, m_ovf[k]});
      end
   endtask

   // Asynchronous reset pulse placed between clock edges; receivers reset too.
   task automatic async_reset(input string tag);
      #1;
      rst_n   = 1'b0;
      ack_tog = 2'b00;
      #1;
      check_reset_values(tag);
      model_reset();
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      evt_pulse = 1'b0;
      clr_ovf   = 1'b0;
      ack_tog   = 2'b00;
      hold      = '{1'b0, 1'b0};
      dly       = '{3, 3};
      model_reset();
      #12;
      check_reset_values("por");
      #1;
      rst_n = 1'b1;

      // Single event with ack looped back after 3 cycles.
      step(1'b1, 1'b0);
      check("single_pend_after_e0", pend_of(0), 32'd1);
      check("single_sig_after_e0", {31'd0, sig_tog[0]}, 32'd0);
      step(1'b0, 1'b0);
      check("single_sig_after_e1", {31'd0, sig_tog[0]}, 32'd1);
      for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
      check("single_idle_busy", {31'd0, busy[0]}, 32'd0);

      // Burst of 5 back-to-back events, then drain.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
      for (int i = 0; i < 60; i++) step(1'b0, 1'b0);
      check("burst_sig_b", {31'd0, sig_tog[1]}, 32'd0);
      check("burst_pend_b", pend_of(1), 32'd0);
      step(1'b0, 1'b1);

      // Saturation with the acknowledge held constant.
      hold = '{1'b1, 1'b1};
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
      check("sat_pend_a", pend_of(0), 32'd3);
      check("sat_ovf_a", {31'd0, overflow[0]}, 32'd1);
      step(1'b0, 1'b1);
      check("clr_ovf_a", {31'd0, overflow[0]}, 32'd0);
      step(1'b1, 1'b1);
      check("set_wins_ovf_a", {31'd0, overflow[0]}, 32'd1);
      step(1'b0, 1'b1);

      // Event coinciding with every issue at full count: count holds, no overflow.
      hold[0] = 1'b0;
      dly[0]  = 1;
      for (int i = 0; i < 40; i++) begin
         step(pred_issue(0), 1'b0);
         check("full_issue_pend_a", pend_of(0), 32'd3);
         check("full_issue_ovf_a", {31'd0, overflow[0]}, 32'd0);
      end

      // Reset in WAIT_ACK with two events queued.
      async_reset("rst_a");
      hold = '{1'b1, 1'b1};
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      check("prerst_pend_a", pend_of(0), 32'd2);
      async_reset("rst_b");
      hold = '{1'b0, 1'b0};
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0);
         check("postrst_no_toggle_a", {31'd0, sig_tog[0]}, 32'd0);
      end

      // Randomized traffic with random receiver latency.
      rnd_dly = 1'b1;
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
      for (int i = 0; i < 120; i++) step(1'b0, 1'b0);
      check("drain_busy_a", {31'd0, busy[0]}, 32'd0);
      check("drain_busy_b", {31'd0, busy[1]}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/toggle_event_tx.md
TOGGLE_EVENT_TX -- requirements
Module: toggle_event_tx

Interface
REQ-001 Parameter CNT_W, 4, width of the pending-event counter (>=1).
REQ-002 Parameter GAP_CYC, 2, idle cycles enforced after each completed handshake (0..255).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 evt_pulse  input  1  single-cycle event request, synchronous to clk.
REQ-006 ack_tog  input  1  acknowledge toggle from the receiving domain, asynchronous to clk.
REQ-007 clr_ovf  input  1  synchronous clear of overflow.
REQ-008 sig_tog  output  1  event toggle level to the receiver; one transition per event.
REQ-009 pending  output  CNT_W  count of accepted events not yet issued.
REQ-010 busy  output  1  high while state != IDLE or pending != 0.
REQ-011 overflow  output  1  sticky flag; an event was dropped.

Function
REQ-012 The block SHALL synchronize ack_tog through two flops (ack_s0, ack_s) clocked by clk before any use.
REQ-013 The pending counter SHALL increment by 1 on an edge where evt_pulse=1, decrement by 1 on an edge where an issue occurs, and stay unchanged when both occur on the same edge.
REQ-014 When pending = 2^CNT_W-1 and evt_pulse=1 with no simultaneous issue, the event SHALL be dropped, pending SHALL hold, and overflow SHALL set.
REQ-015 When pending = 2^CNT_W-1 and evt_pulse=1 with a simultaneous issue, the event SHALL be accepted (pending unchanged) and overflow SHALL NOT set.
REQ-016 FSM states: IDLE, WAIT_ACK, GAP.
REQ-017 IDLE: if registered pending != 0, on the next edge the block SHALL invert sig_tog, decrement pending and enter WAIT_ACK; otherwise remain in IDLE.
REQ-018 An evt_pulse in IDLE with pending=0 SHALL be issued one edge later: pending=1 after edge N, sig_tog flips at edge N+1.
REQ-019 WAIT_ACK: when ack_s == sig_tog, on the next edge the block SHALL enter GAP with the gap counter loaded to GAP_CYC, or enter IDLE directly if GAP_CYC=0.
REQ-020 WAIT_ACK with no acknowledge SHALL persist indefinitely; no timeout exists.
REQ-021 GAP: the gap counter SHALL decrement each edge, and the FSM SHALL enter IDLE on the edge where the counter reaches 0; exactly GAP_CYC cycles are spent in GAP.
REQ-022 sig_tog SHALL change only on the IDLE->WAIT_ACK transition and never twice without an intervening acknowledge.
REQ-023 evt_pulse SHALL be accepted in every state, including WAIT_ACK and GAP.
REQ-024 clr_ovf=1 SHALL clear overflow on the next edge; a simultaneous set condition SHALL win (overflow=1).
REQ-025 busy, pending and overflow SHALL be registered or a pure function of registered state, with no combinational path from any input.

Reset
REQ-026 rst_n=0 SHALL immediately force: sig_tog=0, pending=0, overflow=0, busy=0, state=IDLE, gap counter=0, ack_s0=ack_s=0.
REQ-027 Reset asserted mid-handshake SHALL discard all pending events; after release the block SHALL issue nothing until a new evt_pulse arrives.
REQ-028 The receiver and ack_tog SHALL be reset to 0 together with this block; the block performs no level re-alignment.

Verification
REQ-029 Single event, GAP_CYC=2, ack looped back after 3 cycles: evt_pulse at edge 0 -> pending=1 after edge 0, sig_tog 0->1 at edge 1, WAIT_ACK until ack_s=1, 2 GAP cycles, IDLE, busy=0.
REQ-030 Burst of 5 back-to-back evt_pulse, CNT_W=4: pending peaks at 4 or 5; exactly 5 sig_tog transitions, each separated by ack plus 2 GAP cycles; final pending=0.
REQ-031 CNT_W=2, ack held constant, 5 pulses: first issued, pending saturates at 3, fifth pulse sets overflow=1; clr_ovf -> overflow=0 next edge.
REQ-032 Simultaneous issue and evt_pulse at pending=3 (CNT_W=2): pending stays 3, overflow stays 0.
REQ-033 rst_n pulsed low while in WAIT_ACK with pending=2: outputs go to reset values asynchronously; no toggle after release without a new event.
REQ-034 GAP_CYC=0, ack looped back after 3 cycles: WAIT_ACK->IDLE directly; the next queued event toggles one edge after the return to IDLE.
